id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 199 +++++++++++++++++++
 tb/tb_id_ex_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Optional macro FORWARD_EN enables ExMem/MemWb forwarding and the load-use rule.
module id_ex_reg #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_con_Valid,
    input  logic              i_con_Stall,
    input  logic              i_con_Flush,

    input  logic [DATA_W-1:0] i_data_Rs,
    input  logic [DATA_W-1:0] i_data_Rt,
    input  logic [DATA_W-1:0] i_data_Imm,
    input  logic [4:0]        i_addr_Rs,
    input  logic [4:0]        i_addr_Rt,
    input  logic [4:0]        i_addr_Dst,

    input  logic              i_con_AluSrc,
    input  logic [3:0]        i_con_AluCtrl,
    input  logic [4:0]        i_data_shamt,
    input  logic              i_con_RegWrite,
    input  logic              i_con_MemRead,
    input  logic              i_con_MemWrite,

    input  logic              i_con_ExMemRegWrite,
    input  logic [4:0]        i_addr_ExMemRd,
    input  logic [DATA_W-1:0] i_data_ExMemRes,
    input  logic              i_con_MemWbRegWrite,
    input  logic [4:0]        i_addr_MemWbRd,
    input  logic [DATA_W-1:0] i_data_MemWbRes,

    output logic              o_con_Valid,
    output logic [DATA_W-1:0] o_data_A,
    output logic [DATA_W-1:0] o_data_B,
    output logic [DATA_W-1:0] o_data_StoreData,
    output logic [3:0]        o_con_AluCtrl,
    output logic [4:0]        o_data_shamt,
    output logic [4:0]        o_addr_Dst,
    output logic              o_con_RegWrite,
    output logic              o_con_MemRead,
    output logic              o_con_MemWrite,
    output logic              o_con_Hazard
);

    // Flow control: i_con_Valid marks a real instruction in ID. An instruction
    // moves ID->EX on any edge where Flush, Stall and o_con_Hazard are all low;
    // while o_con_Hazard is high the ID stage must hold its instruction, and the
    // EX slot is filled with a bubble (Valid=0, no writes) instead.

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d;
    logic [DATA_W-1:0] rt_val_q, rt_val_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_addr_q, rs_addr_d;
    logic [4:0]        rt_addr_q, rt_addr_d;
    logic [4:0]        dst_q, dst_d;
    logic              alu_src_q, alu_src_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [4:0]        shamt_q, shamt_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              hazard;

`ifdef FORWARD_EN
    always_comb begin
        fwd_rs = rs_val_q;
        fwd_rt = rt_val_q;
        if (i_con_ExMemRegWrite && i_addr_ExMemRd == rs_addr_q && rs_addr_q != 5'd0)
            fwd_rs = i_data_ExMemRes;
        else if (i_con_MemWbRegWrite && i_addr_MemWbRd == rs_addr_q && rs_addr_q != 5'd0)
            fwd_rs = i_data_MemWbRes;
        if (i_con_ExMemRegWrite && i_addr_ExMemRd == rt_addr_q && rt_addr_q != 5'd0)
            fwd_rt = i_data_ExMemRes;
        else if (i_con_MemWbRegWrite && i_addr_MemWbRd == rt_addr_q && rt_addr_q != 5'd0)
            fwd_rt = i_data_MemWbRes;
    end

    // Only a load in EX cannot be forwarded in time; everything else bypasses.
    assign hazard = valid_q && mem_read_q && (dst_q != 5'd0) && i_con_Valid &&
                    (i_addr_Rs == dst_q || i_addr_Rt == dst_q);
`else
    logic rs_dep;
    logic rt_dep;
    logic unused_fwd;

    assign fwd_rs = rs_val_q;
    assign fwd_rt = rt_val_q;

    // Without bypassing, any pending producer in EX or ExMem blocks the reader.
    assign rs_dep = (i_addr_Rs != 5'd0) &&
                    ((valid_q && reg_write_q && i_addr_Rs == dst_q) ||
                     (i_con_ExMemRegWrite && i_addr_Rs == i_addr_ExMemRd));
    assign rt_dep = (i_addr_Rt != 5'd0) &&
                    ((valid_q && reg_write_q && i_addr_Rt == dst_q) ||
                     (i_con_ExMemRegWrite && i_addr_Rt == i_addr_ExMemRd));
    assign hazard = i_con_Valid && (rs_dep || rt_dep);
    assign unused_fwd = ^{i_data_ExMemRes, i_con_MemWbRegWrite, i_addr_MemWbRd,
                          i_data_MemWbRes, rs_addr_q, rt_addr_q};
`endif

    always_comb begin
        valid_d     = valid_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        dst_d       = dst_q;
        alu_src_d   = alu_src_q;
        alu_ctrl_d  = alu_ctrl_q;
        shamt_d     = shamt_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (i_con_Flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (i_con_Stall) begin
`ifdef FORWARD_EN
            // Capture bypassed operands so a value retiring from MemWb survives the stall.
            rs_val_d = fwd_rs;
            rt_val_d = fwd_rt;
`endif
        end else if (hazard) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else begin
            valid_d     = i_con_Valid;
            rs_val_d    = i_data_Rs;
            rt_val_d    = i_data_Rt;
            imm_d       = i_data_Imm;
            rs_addr_d   = i_addr_Rs;
            rt_addr_d   = i_addr_Rt;
            dst_d       = i_addr_Dst;
            alu_src_d   = i_con_AluSrc;
            alu_ctrl_d  = i_con_AluCtrl;
            shamt_d     = i_data_shamt;
            reg_write_d = i_con_Valid && i_con_RegWrite;
            mem_read_d  = i_con_Valid && i_con_MemRead;
            mem_write_d = i_con_Valid && i_con_MemWrite;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            rs_addr_q   <= 5'd0;
            rt_addr_q   <= 5'd0;
            dst_q       <= 5'd0;
            alu_src_q   <= 1'b0;
            alu_ctrl_q  <= 4'd0;
            shamt_q     <= 5'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            dst_q       <= dst_d;
            alu_src_q   <= alu_src_d;
            alu_ctrl_q  <= alu_ctrl_d;
            shamt_q     <= shamt_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign o_con_Valid      = valid_q;
    assign o_data_A         = fwd_rs;
    assign o_data_StoreData = fwd_rt;
    assign o_data_B         = alu_src_q ? imm_q : fwd_rt;
    assign o_con_AluCtrl    = alu_ctrl_q;
    assign o_data_shamt     = shamt_q;
    assign o_addr_Dst       = dst_q;
    assign o_con_RegWrite   = reg_write_q;
    assign o_con_MemRead    = mem_read_q;
    assign o_con_MemWrite   = mem_write_q;
    assign o_con_Hazard     = hazard;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: a vector table of single-edge cases plus
// hand sequences for forwarding and stall retention (both FORWARD_EN builds).
module tb_id_ex_reg;

    localparam int DW = 32;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          i_rst_n, i_con_Valid, i_con_Stall, i_con_Flush;
    logic [DW-1:0] i_data_Rs, i_data_Rt, i_data_Imm;
    logic [4:0]    i_addr_Rs, i_addr_Rt, i_addr_Dst;
    logic          i_con_AluSrc;
    logic [3:0]    i_con_AluCtrl;
    logic [4:0]    i_data_shamt;
    logic          i_con_RegWrite, i_con_MemRead, i_con_MemWrite;
    logic          i_con_ExMemRegWrite, i_con_MemWbRegWrite;
    logic [4:0]    i_addr_ExMemRd, i_addr_MemWbRd;
    logic [DW-1:0] i_data_ExMemRes, i_data_MemWbRes;

    logic          o_con_Valid;
    logic [DW-1:0] o_data_A, o_data_B, o_data_StoreData;
    logic [3:0]    o_con_AluCtrl;
    logic [4:0]    o_data_shamt, o_addr_Dst;
    logic          o_con_RegWrite, o_con_MemRead, o_con_MemWrite, o_con_Hazard;

    id_ex_reg #(.DATA_W(DW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_con_Valid(i_con_Valid), .i_con_Stall(i_con_Stall), .i_con_Flush(i_con_Flush),
        .i_data_Rs(i_data_Rs), .i_data_Rt(i_data_Rt), .i_data_Imm(i_data_Imm),
        .i_addr_Rs(i_addr_Rs), .i_addr_Rt(i_addr_Rt), .i_addr_Dst(i_addr_Dst),
        .i_con_AluSrc(i_con_AluSrc), .i_con_AluCtrl(i_con_AluCtrl), .i_data_shamt(i_data_shamt),
        .i_con_RegWrite(i_con_RegWrite), .i_con_MemRead(i_con_MemRead),
        .i_con_MemWrite(i_con_MemWrite),
        .i_con_ExMemRegWrite(i_con_ExMemRegWrite), .i_addr_ExMemRd(i_addr_ExMemRd),
        .i_data_ExMemRes(i_data_ExMemRes),
        .i_con_MemWbRegWrite(i_con_MemWbRegWrite), .i_addr_MemWbRd(i_addr_MemWbRd),
        .i_data_MemWbRes(i_data_MemWbRes),
        .o_con_Valid(o_con_Valid), .o_data_A(o_data_A), .o_data_B(o_data_B),
        .o_data_StoreData(o_data_StoreData), .o_con_AluCtrl(o_con_AluCtrl),
        .o_data_shamt(o_data_shamt), .o_addr_Dst(o_addr_Dst),
        .o_con_RegWrite(o_con_RegWrite), .o_con_MemRead(o_con_MemRead),
        .o_con_MemWrite(o_con_MemWrite), .o_con_Hazard(o_con_Hazard)
    );

    typedef struct {
        logic          rst_n, valid, stall, flush;
        logic [4:0]    rs_a;
        logic [DW-1:0] rs_d;
        logic [4:0]    rt_a;
        logic [DW-1:0] rt_d, imm;
        logic          alusrc;
        logic [3:0]    aluctrl;
        logic [4:0]    shamt, dst;
        logic          rw, mr, mw;
        logic          e_valid;
        logic [DW-1:0] e_a, e_b, e_st;
        logic [3:0]    e_ctrl;
        logic [4:0]    e_shamt, e_dst;
        logic          e_rw, e_mr, e_mw, e_haz;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk_in(logic rst_n, logic valid, logic stall, logic flush,
                                   logic [4:0] rs_a, logic [DW-1:0] rs_d,
                                   logic [4:0] rt_a, logic [DW-1:0] rt_d,
                                   logic [DW-1:0] imm, logic alusrc, logic [3:0] aluctrl,
                                   logic [4:0] shamt, logic [4:0] dst,
                                   logic rw, logic mr, logic mw);
        vec_t v;
        v = '{default: '0};
        v.rst_n = rst_n; v.valid = valid; v.stall = stall; v.flush = flush;
        v.rs_a = rs_a; v.rs_d = rs_d; v.rt_a = rt_a; v.rt_d = rt_d; v.imm = imm;
        v.alusrc = alusrc; v.aluctrl = aluctrl; v.shamt = shamt; v.dst = dst;
        v.rw = rw; v.mr = mr; v.mw = mw;
        return v;
    endfunction

    function automatic vec_t with_exp(vec_t v_in, logic valid, logic [DW-1:0] a,
                                      logic [DW-1:0] b, logic [DW-1:0] st, logic [3:0] ctrl,
                                      logic [4:0] shamt, logic [4:0] dst,
                                      logic rw, logic mr, logic mw, logic haz);
        vec_t v;
        v = v_in;
        v.e_valid = valid; v.e_a = a; v.e_b = b; v.e_st = st; v.e_ctrl = ctrl;
        v.e_shamt = shamt; v.e_dst = dst; v.e_rw = rw; v.e_mr = mr; v.e_mw = mw;
        v.e_haz = haz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fwd(input logic em_rw, input logic [4:0] em_rd, input logic [DW-1:0] em_res,
                           input logic mw_rw, input logic [4:0] mw_rd, input logic [DW-1:0] mw_res);
        i_con_ExMemRegWrite = em_rw; i_addr_ExMemRd = em_rd; i_data_ExMemRes = em_res;
        i_con_MemWbRegWrite = mw_rw; i_addr_MemWbRd = mw_rd; i_data_MemWbRes = mw_res;
    endtask

    task automatic drive_vec(input vec_t v);
        i_rst_n = v.rst_n; i_con_Valid = v.valid; i_con_Stall = v.stall; i_con_Flush = v.flush;
        i_addr_Rs = v.rs_a; i_data_Rs = v.rs_d; i_addr_Rt = v.rt_a; i_data_Rt = v.rt_d;
        i_data_Imm = v.imm; i_con_AluSrc = v.alusrc; i_con_AluCtrl = v.aluctrl;
        i_data_shamt = v.shamt; i_addr_Dst = v.dst;
        i_con_RegWrite = v.rw; i_con_MemRead = v.mr; i_con_MemWrite = v.mw;
        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d_valid", i), DW'(o_con_Valid), DW'(v.e_valid));
        chk($sformatf("v%0d_A", i), o_data_A, v.e_a);
        chk($sformatf("v%0d_B", i), o_data_B, v.e_b);
        chk($sformatf("v%0d_store", i), o_data_StoreData, v.e_st);
        chk($sformatf("v%0d_aluctrl", i), DW'(o_con_AluCtrl), DW'(v.e_ctrl));
        chk($sformatf("v%0d_shamt", i), DW'(o_data_shamt), DW'(v.e_shamt));
        chk($sformatf("v%0d_dst", i), DW'(o_addr_Dst), DW'(v.e_dst));
        chk($sformatf("v%0d_regwrite", i), DW'(o_con_RegWrite), DW'(v.e_rw));
        chk($sformatf("v%0d_memread", i), DW'(o_con_MemRead), DW'(v.e_mr));
        chk($sformatf("v%0d_memwrite", i), DW'(o_con_MemWrite), DW'(v.e_mw));
        chk($sformatf("v%0d_hazard", i), DW'(o_con_Hazard), DW'(v.e_haz));
    endtask

    initial begin
        // Reset with busy inputs: nothing may leak through.
        vecs[0]  = with_exp(mk_in(0,1,0,0, 5,32'h1234, 6,32'h5678, 32'h9, 1,4'h3,5'd7,5'd9, 1,1,1),
                            0, 0, 0, 0, 0, 0, 0, 0,0,0, 0);
        vecs[1]  = with_exp(mk_in(1,1,0,0, 1,32'h11, 2,32'h22, 32'h0000FFFC, 1,4'd2,5'd3,5'd4, 1,0,0),
                            1, 32'h11, 32'h0000FFFC, 32'h22, 4'd2, 5'd3, 5'd4, 1,0,0, 0);
        vecs[2]  = with_exp(mk_in(1,1,0,0, 6,32'hA5A5A5A5, 7,32'h5A5A5A5A, 32'h10, 0,4'hF,5'd31,5'd9, 0,0,1),
                            1, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 4'hF, 5'd31, 5'd9, 0,0,1, 0);
        // Invalid ID instruction: controls must load as zero.
        vecs[3]  = with_exp(mk_in(1,0,0,0, 13,32'h33, 14,32'h44, 32'h50, 0,4'd5,5'd2,5'd12, 1,1,1),
                            0, 32'h33, 32'h44, 32'h44, 4'd5, 5'd2, 5'd12, 0,0,0, 0);
        vecs[4]  = with_exp(mk_in(1,1,0,0, 1,32'h100, 2,32'h200, 32'h0, 0,4'd1,5'd0,5'd3, 1,1,0),
                            1, 32'h100, 32'h200, 32'h200, 4'd1, 5'd0, 5'd3, 1,1,0, 0);
        vecs[5]  = with_exp(mk_in(1,1,1,0, 10,32'hDEAD, 11,32'hBEEF, 32'h7, 1,4'd7,5'd9,5'd20, 0,0,1),
                            1, 32'h100, 32'h200, 32'h200, 4'd1, 5'd0, 5'd3, 1,1,0, 0);
        // Flush wins over Stall on the same edge.
        vecs[6]  = with_exp(mk_in(1,1,1,1, 10,32'hDEAD, 11,32'hBEEF, 32'h7, 1,4'd7,5'd9,5'd20, 0,0,1),
                            0, 32'h100, 32'h200, 32'h200, 4'd1, 5'd0, 5'd3, 0,0,0, 0);
        // lw r8 enters EX while ID still reads r8.
        vecs[7]  = with_exp(mk_in(1,1,0,0, 8,32'h1, 9,32'h2, 32'h0, 0,4'd0,5'd0,5'd8, 1,1,0),
                            1, 32'h1, 32'h2, 32'h2, 4'd0, 5'd0, 5'd8, 1,1,0, 1);
        vecs[8]  = with_exp(mk_in(1,1,0,0, 8,32'h80, 0,32'h77, 32'h0, 0,4'd3,5'd0,5'd10, 1,0,0),
                            0, 32'h1, 32'h2, 32'h2, 4'd0, 5'd0, 5'd8, 0,0,0, 0);
        vecs[9]  = with_exp(mk_in(1,1,0,0, 8,32'h80, 0,32'h77, 32'h0, 0,4'd3,5'd0,5'd10, 1,0,0),
                            1, 32'h80, 32'h77, 32'h77, 4'd3, 5'd0, 5'd10, 1,0,0, 0);
        // Reset while Stall and Flush are both asserted.
        vecs[10] = with_exp(mk_in(0,1,1,1, 3,32'h5, 4,32'h6, 32'h7, 1,4'd9,5'd1,5'd2, 1,1,1),
                            0, 0, 0, 0, 0, 0, 0, 0,0,0, 0);

        for (int i = 0; i < NV; i++) begin
            drive_vec(vecs[i]);
            @(posedge i_clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // Forwarding priority: EX holds Rs=5 (0x10), Rt=0 (0x20).
        drive_vec(mk_in(1,1,0,0, 5,32'h10, 0,32'h20, 32'h0, 0,4'd0,5'd0,5'd1, 0,0,0));
        @(posedge i_clk);
        #1;
        i_con_Valid = 1'b0;
        i_con_Stall = 1'b1;
        chk("fwd_none_A", o_data_A, 32'h10);
        set_fwd(1'b1, 5'd5, 32'h99, 1'b1, 5'd5, 32'h77);
        #1;
        chk("fwd_exmem_A", o_data_A, FWD ? 32'h99 : 32'h10);
        set_fwd(1'b0, 5'd5, 32'h99, 1'b1, 5'd5, 32'h77);
        #1;
        chk("fwd_memwb_A", o_data_A, FWD ? 32'h77 : 32'h10);
        set_fwd(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
        #1;
        chk("fwd_rd0_A", o_data_A, 32'h10);
        chk("fwd_rd0_B", o_data_B, 32'h20);
        // ExMem producer of r7 blocks ID only when there is no bypass path.
        i_con_Valid = 1'b1;
        i_addr_Rs = 5'd7;
        i_addr_Rt = 5'd0;
        set_fwd(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, '0);
        #1;
        chk("exmem_hazard", DW'(o_con_Hazard), FWD ? 32'd0 : 32'd1);
        i_con_Valid = 1'b0;
        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

        // Stall retention of a MemWb value that is only present for one cycle.
        drive_vec(mk_in(1,1,0,0, 2,32'h2222, 3,32'h1111, 32'h0, 0,4'd0,5'd0,5'd1, 1,0,0));
        @(posedge i_clk);
        #1;
        chk("ret_load_B", o_data_B, 32'h1111);
        i_con_Valid = 1'b0;
        i_con_Stall = 1'b1;
        set_fwd(1'b0, 5'd0, '0, 1'b1, 5'd3, 32'hABCD);
        #1;
        chk("ret_live_B", o_data_B, FWD ? 32'hABCD : 32'h1111);
        @(posedge i_clk);
        #1;
        set_fwd(1'b0, 5'd0, '0, 1'b1, 5'd4, 32'h5555);
        #1;
        chk("ret_hold1_B", o_data_B, FWD ? 32'hABCD : 32'h1111);
        chk("ret_hold1_valid", DW'(o_con_Valid), 32'd1);
        @(posedge i_clk);
        #1;
        chk("ret_hold2_B", o_data_B, FWD ? 32'hABCD : 32'h1111);
        chk("ret_hold2_store", o_data_StoreData, FWD ? 32'hABCD : 32'h1111);
        chk("ret_hold2_A", o_data_A, 32'h2222);
        i_con_Stall = 1'b0;
        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(posedge i_clk);
        #1;
        chk("ret_release_valid", DW'(o_con_Valid), 32'd0);
        chk("ret_release_rw", DW'(o_con_RegWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
